// File: rtl/btb_fetch_pred_pkg.sv
// Shared types for the fetch-side BTB consumer: BTB entry/update bus layouts
// and the in-flight prediction queue entry.
package btb_fetch_pred_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned BTB_ENTRY_SIZE = 2 * ADDR_WIDTH;
  localparam int unsigned PRED_QDEPTH    = 4;
  localparam int unsigned PC_INC         = 4;

  // Tag PC sits in the low half, predicted target in the high half.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] tag;
  } btb_entry_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  is_taken;
  } br_cntrl_bus_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
  } pred_q_entry_t;

endpackage

// File: rtl/btb_fetch_pred_fifo.sv
// Prediction queue: synchronous FIFO of taken predictions awaiting resolution,
// with a flush that clears it on mispredict.
module btb_fetch_pred_fifo
  import btb_fetch_pred_pkg::*;
#(
  parameter int unsigned DEPTH = PRED_QDEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  pred_q_entry_t din_i,
  output pred_q_entry_t head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  pred_q_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/btb_fetch_pred.sv
// Fetch PC owner: follows BTB hits, queues taken predictions, checks them at
// resolution, redirects on mispredict and drives the BTB update bus.
module btb_fetch_pred
  import btb_fetch_pred_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       QDEPTH   = PRED_QDEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  output logic [ADDR_W-1:0]         pc_o,
  output logic                      pc_valid_o,
  output logic [ADDR_W-1:0]         btb_raddr_o,
  input  logic [BTB_ENTRY_SIZE-1:0] btb_entry_i,
  input  logic                      res_valid_i,
  input  logic [ADDR_W-1:0]         res_pc_i,
  input  logic                      res_taken_i,
  input  logic [ADDR_W-1:0]         res_target_i,
  output logic                      redirect_o,
  output logic [ADDR_W-1:0]         redirect_pc_o,
  output br_cntrl_bus_t             br_cntrl_o,
  output logic                      is_branch_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] res_inc, pred_next, act_next;
  btb_entry_t        entry;
  pred_q_entry_t     head, push_entry;
  logic              hit, acc, match, push, pop;
  logic              q_full, q_empty;

  assign entry       = btb_entry_t'(btb_entry_i);
  assign hit         = (btb_entry_i != '0) && (entry.tag == pc_q);
  assign pc_o        = pc_q;
  assign btb_raddr_o = pc_q;
  assign pc_valid_o  = !rst && !stall_i && !q_full;
  assign acc         = pc_valid_o && !redirect_o;

  // Resolution check against the oldest queued prediction.
  assign res_inc       = res_pc_i + ADDR_W'(PC_INC);
  assign match         = !q_empty && (head.pc == res_pc_i);
  assign pred_next     = match ? head.target : res_inc;
  assign act_next      = res_taken_i ? res_target_i : res_inc;
  assign redirect_o    = !rst && res_valid_i && (pred_next != act_next);
  assign redirect_pc_o = act_next;

  assign is_branch_o              = !rst && res_valid_i;
  assign br_cntrl_o.i_addr        = res_pc_i;
  assign br_cntrl_o.branch_target = res_target_i;
  assign br_cntrl_o.is_taken      = res_taken_i;

  assign push              = acc && hit;
  assign pop               = res_valid_i && match;
  assign push_entry.pc     = pc_q;
  assign push_entry.target = entry.target;

  always_comb begin
    pc_d = pc_q;
    if (redirect_o)  pc_d = redirect_pc_o;
    else if (!acc)   pc_d = pc_q;
    else if (hit)    pc_d = entry.target;
    else             pc_d = pc_q + ADDR_W'(PC_INC);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  btb_fetch_pred_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_o),
    .din_i   (push_entry),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_btb_fetch_pred.sv
// Bench for btb_fetch_pred: directed plan steps plus random traffic, checked
// against a queue-based model of fetch, prediction and resolution.
module tb_btb_fetch_pred;
  import btb_fetch_pred_pkg::*;

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned QD = PRED_QDEPTH;
  localparam logic [AW-1:0] RPC = '0;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      stall_i;
  logic [AW-1:0]             pc_o;
  logic                      pc_valid_o;
  logic [AW-1:0]             btb_raddr_o;
  logic [BTB_ENTRY_SIZE-1:0] btb_entry_i;
  logic                      res_valid_i;
  logic [AW-1:0]             res_pc_i;
  logic                      res_taken_i;
  logic [AW-1:0]             res_target_i;
  logic                      redirect_o;
  logic [AW-1:0]             redirect_pc_o;
  br_cntrl_bus_t             br_cntrl_o;
  logic                      is_branch_o;

  int total = 0;
  int bad   = 0;

  // Model state: fetch PC, in-flight predictions, BTB contents (pc -> target).
  logic [AW-1:0] mpc;
  pred_q_entry_t mq[$];
  logic [AW-1:0] btb_tgt [logic [AW-1:0]];

  always #5 clk = ~clk;

  btb_fetch_pred u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .btb_raddr_o   (btb_raddr_o),
    .btb_entry_i   (btb_entry_i),
    .res_valid_i   (res_valid_i),
    .res_pc_i      (res_pc_i),
    .res_taken_i   (res_taken_i),
    .res_target_i  (res_target_i),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .br_cntrl_o    (br_cntrl_o),
    .is_branch_o   (is_branch_o)
  );

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    stall_i      = 1'($urandom_range(1));
    res_valid_i  = 1'b0;
    res_pc_i     = '0;
    res_taken_i  = 1'b0;
    res_target_i = '0;
    btb_entry_i  = {AW'($urandom), AW'($urandom)};
    #1;
    chk("rst_pc_valid", AW'(pc_valid_o), '0);
    chk("rst_redirect", AW'(redirect_o), '0);
    chk("rst_is_branch", AW'(is_branch_o), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    mpc = RPC;
    mq.delete();
    chk("rst_pc", pc_o, mpc);
    chk("rst_count", AW'(u_dut.u_fifo.count_q), '0);
  endtask

  // One fetch cycle: drive inputs, check same-cycle outputs, advance the model.
  task automatic step(input logic st, input logic rv, input logic [AW-1:0] rpc,
                      input logic rt, input logic [AW-1:0] rtg);
    logic          hit, valid, acc, match, redir;
    logic [AW-1:0] tgt, pnext, anext, npc;
    hit = btb_tgt.exists(mpc);
    tgt = hit ? btb_tgt[mpc] : '0;
    stall_i      = st;
    res_valid_i  = rv;
    res_pc_i     = rpc;
    res_taken_i  = rt;
    res_target_i = rtg;
    btb_entry_i  = hit ? {tgt, mpc} : {AW'($urandom), mpc ^ AW'(4)};
    match = (mq.size() != 0) && (mq[0].pc == rpc);
    pnext = match ? mq[0].target : rpc + AW'(4);
    anext = rt ? rtg : rpc + AW'(4);
    redir = rv && (pnext != anext);
    valid = !st && (mq.size() < QD);
    acc   = valid && !redir;
    #1;
    chk("pc", pc_o, mpc);
    chk("raddr", btb_raddr_o, mpc);
    chk("pc_valid", AW'(pc_valid_o), AW'(valid));
    chk("redirect", AW'(redirect_o), AW'(redir));
    if (redir) chk("redirect_pc", redirect_pc_o, anext);
    chk("is_branch", AW'(is_branch_o), AW'(rv));
    if (rv) begin
      chk("upd_addr", br_cntrl_o.i_addr, rpc);
      chk("upd_tgt", br_cntrl_o.branch_target, rtg);
      chk("upd_taken", AW'(br_cntrl_o.is_taken), AW'(rt));
    end
    chk("count", AW'(u_dut.u_fifo.count_q), AW'(mq.size()));
    if (redir)     npc = anext;
    else if (!acc) npc = mpc;
    else if (hit)  npc = tgt;
    else           npc = mpc + AW'(4);
    if (redir) mq.delete();
    else begin
      if (rv && match) void'(mq.pop_front());
      if (acc && hit) mq.push_back('{pc: mpc, target: tgt});
    end
    mpc = npc;
    @(posedge clk); #1;
  endtask

  initial begin
    logic          st, rv, rt;
    logic [AW-1:0] rpc, rtg;

    do_reset();
    // Empty BTB: sequential fetch, nothing queued.
    btb_tgt.delete();
    repeat (4) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("seq_pc", pc_o, AW'(32'h10));
    chk("seq_count", AW'(u_dut.u_fifo.count_q), '0);

    // Hit at 0x8 redirects fetch to 0x100; correct taken resolution pops.
    do_reset();
    btb_tgt[AW'(32'h8)] = AW'(32'h100);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("hit_pc", pc_o, AW'(32'h100));
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, AW'(32'h8), 1'b1, AW'(32'h100));
    chk("pop_count", AW'(u_dut.u_fifo.count_q), '0);

    // Queued prediction resolves not-taken: redirect to 0xC and flush.
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, AW'(32'h8), 1'b0, AW'(32'h100));
    chk("mis_pc", pc_o, AW'(32'hC));
    step(1'b0, 1'b0, '0, 1'b0, '0);

    // Empty queue, taken branch: treated as predicted not-taken.
    step(1'b0, 1'b1, AW'(32'h20), 1'b1, AW'(32'h40));
    chk("empty_taken_pc", pc_o, AW'(32'h40));

    // PC +4 wraps at the top of the address space.
    step(1'b0, 1'b1, AW'(32'h20), 1'b1, AW'(32'hFFFF_FFFC));
    step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("wrap_pc", pc_o, '0);
    step(1'b0, 1'b1, AW'(32'hFFFF_FFFC), 1'b0, '0);

    // Tight loop 0<->4 fills the queue, fetch holds, a correct resolve frees it.
    do_reset();
    btb_tgt.delete();
    btb_tgt[AW'(32'h0)] = AW'(32'h4);
    btb_tgt[AW'(32'h4)] = AW'(32'h0);
    repeat (6) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("full_valid", AW'(pc_valid_o), '0);
    step(1'b0, 1'b1, '0, 1'b1, AW'(32'h4));
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0);

    // Reset with three entries in flight.
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("pre_rst_count", AW'(u_dut.u_fifo.count_q), AW'(3));
    do_reset();

    // Random traffic against a randomly populated BTB.
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) begin
        btb_tgt.delete();
        for (int k = 0; k < 6; k++)
          btb_tgt[AW'($urandom_range(15) * 4)] = AW'($urandom_range(1, 15) * 4);
      end
      if ($urandom_range(59) == 0) do_reset();
      else begin
        st = ($urandom_range(4) == 0);
        rv = ($urandom_range(2) == 0);
        if (mq.size() != 0 && $urandom_range(3) != 0) rpc = mq[0].pc;
        else rpc = AW'($urandom_range(15) * 4);
        rt = 1'($urandom_range(1));
        if (mq.size() != 0 && $urandom_range(1) == 1) rtg = mq[0].target;
        else rtg = AW'($urandom_range(1, 15) * 4);
        step(st, rv, rpc, rt, rtg);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
